// File: rtl/hc165_pkg.sv
// rtl/hc165_pkg.sv - shared states and phase constants for the 74HC165 chain reader
//
// Contents:
//   state_t      frame FSM states IDLE / ARMED / LOAD / SHIFT
//   PHASES       clk cycles per sclk period
//   PH_W         width of the phase counter
//   SAMPLE_PH    phase on which s_in is captured (sclk low and stable)
//   SCLK_HI_PH   one-hot-per-phase mask of phases with sclk high (phases 1 and 2)
//   BOUNDARY_PH  phase on which FSM state changes are allowed
package hc165_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        LOAD  = 2'd2,
        SHIFT = 2'd3
    } state_t;

    localparam int PHASES = 4;
    localparam int PH_W   = $clog2(PHASES);

    localparam logic [PH_W-1:0]   SAMPLE_PH   = 2'd0;
    localparam logic [PHASES-1:0] SCLK_HI_PH  = 4'b0110;
    localparam logic [PH_W-1:0]   BOUNDARY_PH = 2'd3;

endpackage

// File: rtl/hc165_clk_div.sv
// rtl/hc165_clk_div.sv - free-running phase counter with sclk/boundary/sample strobes
//
// Ports:
//   clk       in   system clock
//   rst_n     in   async active-low reset
//   boundary  out  high while phase = BOUNDARY_PH (last clk of a period)
//   sample    out  high while phase = SAMPLE_PH
//   sclk_hi   out  registered, high while phase is 1 or 2
module hc165_clk_div
    import hc165_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    output logic boundary,
    output logic sample,
    output logic sclk_hi
);

    logic [PH_W-1:0] phase;
    logic [PH_W-1:0] phase_nxt;

    assign phase_nxt = phase + 2'd1;

    // sclk_hi is decoded from the next phase and registered so the pin
    // never sees a decode glitch on the 01->10 counter transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase   <= '0;
            sclk_hi <= 1'b0;
        end else begin
            phase   <= phase_nxt;
            sclk_hi <= SCLK_HI_PH[phase_nxt];
        end
    end

    assign boundary = (phase == BOUNDARY_PH);
    assign sample   = (phase == SAMPLE_PH);

endmodule

// File: rtl/hc165_reader.sv
// rtl/hc165_reader.sv - frame reader for a chain of 74HC165 parallel-in/serial-out registers
//
// Ports:
//   clk     in   system clock (50 MHz)
//   rst_n   in   async active-low reset
//   start   in   level-sampled frame request, ignored while busy
//   s_in    in   serial data from Q7 of the last device
//   sclk    out  shift clock, clk/4 while shifting
//   pl_n    out  parallel load, low for one period per frame
//   p_data  out  last completed frame, first received bit at the MSB
//   valid   out  one-clk pulse when p_data updates
//   busy    out  high while a frame is in progress
module hc165_reader
    import hc165_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             s_in,
    output logic             sclk,
    output logic             pl_n,
    output logic [WIDTH-1:0] p_data,
    output logic             valid,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_t           state;
    state_t           state_nxt;
    logic             boundary;
    logic             sample;
    logic             sclk_hi;
    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] shift_reg;
    logic             last_bit;

    hc165_clk_div u_clk_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .boundary (boundary),
        .sample   (sample),
        .sclk_hi  (sclk_hi)
    );

    assign last_bit = (bit_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start)                state_nxt = ARMED;
            ARMED: if (boundary)             state_nxt = LOAD;
            LOAD:  if (boundary)             state_nxt = SHIFT;
            SHIFT: if (boundary && last_bit) state_nxt = IDLE;
            default:                         state_nxt = IDLE;
        endcase
    end

    // State only changes on a boundary, where sclk_hi is already low,
    // so gating it with the state decode cannot glitch the pin.
    assign sclk = (state == SHIFT) && sclk_hi;
    assign pl_n = (state != LOAD);
    assign busy = (state != IDLE);

    // One bit is captured early in each SHIFT period (before that period's
    // sclk rise); the period count advances on the closing boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
            p_data    <= '0;
            valid     <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                LOAD: begin
                    bit_cnt <= '0;
                end
                SHIFT: begin
                    if (sample) begin
                        shift_reg <= {shift_reg[WIDTH-2:0], s_in};
                    end
                    if (boundary) begin
                        if (last_bit) begin
                            p_data <= shift_reg;
                            valid  <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + CW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hc165_reader.sv
// tb/tb_hc165_reader.sv - directed self-checking bench for hc165_reader with a 74HC165 chain model
module tb_hc165_reader;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    // ---------------- WIDTH=16 instance and chain ----------------
    logic        start16 = 1'b0;
    logic        s_in16 = 1'b0;
    logic        sclk16, pl_n16, valid16, busy16;
    logic [15:0] p_data16;
    logic [15:0] pins16 = 16'h0000;
    logic [15:0] chain16 = 16'h0000;

    hc165_reader #(.WIDTH(16)) dut16 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start16),
        .s_in   (s_in16),
        .sclk   (sclk16),
        .pl_n   (pl_n16),
        .p_data (p_data16),
        .valid  (valid16),
        .busy   (busy16)
    );

    always @(posedge sclk16 or negedge pl_n16) begin
        if (!pl_n16) chain16 <= pins16;
        else         chain16 <= {chain16[14:0], 1'b0};
    end
    always @(chain16) s_in16 <= #2 chain16[15];

    int          sclk_rises16 = 0;
    int          pl_falls16 = 0;
    int          pl_low16 = 0;
    int          valid_cnt16 = 0;
    int          pl_fall_cyc16 = 0;
    int          valid_cyc16 = 0;
    logic        pl_prev16 = 1'b1;
    logic [15:0] vdata16 [16];

    always @(posedge sclk16) sclk_rises16 = sclk_rises16 + 1;

    always @(negedge clk) begin
        if (!pl_n16 && pl_prev16) begin
            pl_falls16    = pl_falls16 + 1;
            pl_fall_cyc16 = cyc;
        end
        if (!pl_n16) pl_low16 = pl_low16 + 1;
        pl_prev16 = pl_n16;
        if (valid16) begin
            if (valid_cnt16 < 16) vdata16[valid_cnt16] = p_data16;
            valid_cnt16 = valid_cnt16 + 1;
            valid_cyc16 = cyc;
        end
    end

    // ---------------- WIDTH=8 instance and chain ----------------
    logic       start8 = 1'b0;
    logic       s_in8 = 1'b0;
    logic       sclk8, pl_n8, valid8, busy8;
    logic [7:0] p_data8;
    logic [7:0] pins8 = 8'h00;
    logic [7:0] chain8 = 8'h00;

    hc165_reader #(.WIDTH(8)) dut8 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start8),
        .s_in   (s_in8),
        .sclk   (sclk8),
        .pl_n   (pl_n8),
        .p_data (p_data8),
        .valid  (valid8),
        .busy   (busy8)
    );

    always @(posedge sclk8 or negedge pl_n8) begin
        if (!pl_n8) chain8 <= pins8;
        else        chain8 <= {chain8[6:0], 1'b0};
    end
    always @(chain8) s_in8 <= #2 chain8[7];

    int         sclk_rises8 = 0;
    int         pl_low8 = 0;
    int         valid_cnt8 = 0;
    int         pl_fall_cyc8 = 0;
    int         valid_cyc8 = 0;
    logic       pl_prev8 = 1'b1;
    logic [7:0] vdata8 = 8'h00;

    always @(posedge sclk8) sclk_rises8 = sclk_rises8 + 1;

    always @(negedge clk) begin
        if (!pl_n8 && pl_prev8) pl_fall_cyc8 = cyc;
        if (!pl_n8) pl_low8 = pl_low8 + 1;
        pl_prev8 = pl_n8;
        if (valid8) begin
            vdata8     = p_data8;
            valid_cnt8 = valid_cnt8 + 1;
            valid_cyc8 = cyc;
        end
    end

    // ---------------- helpers ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic pulse_start16();
        start16 = 1'b1;
        step(1);
        start16 = 1'b0;
    endtask

    task automatic wait_valid16(input int target, input int budget, input string name);
        int waited = 0;
        while (valid_cnt16 < target && waited < budget) begin
            step(1);
            waited++;
        end
        checks++;
        if (valid_cnt16 < target) begin
            failures++;
            $display("FAIL %s_timeout: valid count %0d, required %0d within %0d clk", name, valid_cnt16, target, budget);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        step(3);
        checks++;
        if ({sclk16, pl_n16, valid16, busy16} !== 4'b0100) begin
            failures++;
            $display("FAIL reset_ctrl16: sclk/pl_n/valid/busy=%b required 0100", {sclk16, pl_n16, valid16, busy16});
        end
        checks++;
        if (p_data16 !== 16'h0000) begin
            failures++;
            $display("FAIL reset_pdata16: got %h required 0000", p_data16);
        end
        checks++;
        if ({sclk8, pl_n8, valid8, busy8, p_data8} !== {4'b0100, 8'h00}) begin
            failures++;
            $display("FAIL reset_dut8: ctrl=%b p_data=%h required 0100/00", {sclk8, pl_n8, valid8, busy8}, p_data8);
        end
        rst_n = 1'b1;
        step(5);
        checks++;
        if (busy16 !== 1'b0 || pl_falls16 != 0) begin
            failures++;
            $display("FAIL no_auto_start: busy=%b pl_falls=%0d required 0/0", busy16, pl_falls16);
        end
    endtask

    task automatic test_basic_frame();
        int s0 = sclk_rises16, p0 = pl_falls16, l0 = pl_low16, v0 = valid_cnt16;
        pins16 = 16'hA5C3;
        pulse_start16();
        checks++;
        if (busy16 !== 1'b1) begin
            failures++;
            $display("FAIL basic_busy_set: got %b required 1", busy16);
        end
        wait_valid16(v0 + 1, 200, "basic");
        step(10);
        checks++;
        if (vdata16[v0] !== 16'hA5C3) begin
            failures++;
            $display("FAIL basic_data: got %h required a5c3", vdata16[v0]);
        end
        checks++;
        if (sclk_rises16 - s0 != 16) begin
            failures++;
            $display("FAIL basic_sclk_count: got %0d required 16", sclk_rises16 - s0);
        end
        checks++;
        if (pl_falls16 - p0 != 1 || pl_low16 - l0 != 4) begin
            failures++;
            $display("FAIL basic_pl_n: falls=%0d low_clks=%0d required 1/4", pl_falls16 - p0, pl_low16 - l0);
        end
        checks++;
        if (valid_cyc16 - pl_fall_cyc16 != 68) begin
            failures++;
            $display("FAIL basic_latency: got %0d required 68", valid_cyc16 - pl_fall_cyc16);
        end
        checks++;
        if (valid_cnt16 - v0 != 1) begin
            failures++;
            $display("FAIL basic_valid_width: high clks=%0d required 1", valid_cnt16 - v0);
        end
        checks++;
        if (busy16 !== 1'b0 || p_data16 !== 16'hA5C3) begin
            failures++;
            $display("FAIL basic_hold: busy=%b p_data=%h required 0/a5c3", busy16, p_data16);
        end
    endtask

    task automatic test_busy_guard();
        int s0 = sclk_rises16, p0 = pl_falls16, v0 = valid_cnt16;
        pins16 = 16'h1234;
        pulse_start16();
        step(30);
        checks++;
        if (busy16 !== 1'b1 || sclk_rises16 == s0) begin
            failures++;
            $display("FAIL guard_in_shift: busy=%b rises=%0d required busy with shifting", busy16, sclk_rises16 - s0);
        end
        pulse_start16();
        wait_valid16(v0 + 1, 200, "guard");
        step(100);
        checks++;
        if (valid_cnt16 - v0 != 1 || pl_falls16 - p0 != 1) begin
            failures++;
            $display("FAIL guard_single_frame: valids=%0d pl_falls=%0d required 1/1", valid_cnt16 - v0, pl_falls16 - p0);
        end
        checks++;
        if (vdata16[v0] !== 16'h1234 || sclk_rises16 - s0 != 16) begin
            failures++;
            $display("FAIL guard_data: data=%h rises=%0d required 1234/16", vdata16[v0], sclk_rises16 - s0);
        end
    endtask

    task automatic test_back_to_back();
        int v0 = valid_cnt16, p0 = pl_falls16, first_valid;
        pins16 = 16'h0001;
        start16 = 1'b1;
        wait_valid16(v0 + 1, 200, "b2b_first");
        first_valid = valid_cyc16;
        pins16 = 16'h8000;
        wait_valid16(v0 + 2, 200, "b2b_second");
        start16 = 1'b0;
        step(20);
        checks++;
        if (vdata16[v0] !== 16'h0001 || vdata16[v0+1] !== 16'h8000) begin
            failures++;
            $display("FAIL b2b_data: got %h,%h required 0001,8000", vdata16[v0], vdata16[v0+1]);
        end
        checks++;
        if (pl_fall_cyc16 - first_valid > 8 || pl_fall_cyc16 - first_valid < 1) begin
            failures++;
            $display("FAIL b2b_rearm: gap=%0d clk required 1..8", pl_fall_cyc16 - first_valid);
        end
        checks++;
        if (valid_cnt16 - v0 != 2 || pl_falls16 - p0 != 2 || busy16 !== 1'b0) begin
            failures++;
            $display("FAIL b2b_stop: valids=%0d falls=%0d busy=%b required 2/2/0", valid_cnt16 - v0, pl_falls16 - p0, busy16);
        end
    endtask

    task automatic test_reset_mid_shift();
        int s0 = sclk_rises16, v0 = valid_cnt16, waited = 0;
        pins16 = 16'hFFFF;
        pulse_start16();
        while (sclk_rises16 - s0 < 7 && waited < 200) begin
            step(1);
            waited++;
        end
        checks++;
        if (sclk_rises16 - s0 != 7) begin
            failures++;
            $display("FAIL rst_reach_7: rises=%0d required 7", sclk_rises16 - s0);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({sclk16, pl_n16, busy16} !== 3'b010 || p_data16 !== 16'h0000) begin
            failures++;
            $display("FAIL rst_immediate: sclk/pl_n/busy=%b p_data=%h required 010/0000", {sclk16, pl_n16, busy16}, p_data16);
        end
        step(3);
        rst_n = 1'b1;
        step(150);
        checks++;
        if (valid_cnt16 != v0 || p_data16 !== 16'h0000 || busy16 !== 1'b0 || sclk_rises16 - s0 != 7) begin
            failures++;
            $display("FAIL rst_no_frame: valids=%0d p_data=%h busy=%b rises=%0d required 0/0000/0/7", valid_cnt16 - v0, p_data16, busy16, sclk_rises16 - s0);
        end
    endtask

    task automatic test_width8();
        int s0 = sclk_rises8, l0 = pl_low8, v0 = valid_cnt8, waited = 0;
        pins8 = 8'h3C;
        start8 = 1'b1;
        step(1);
        start8 = 1'b0;
        while (valid_cnt8 == v0 && waited < 150) begin
            step(1);
            waited++;
        end
        step(10);
        checks++;
        if (valid_cnt8 - v0 != 1) begin
            failures++;
            $display("FAIL w8_valid: count=%0d required 1", valid_cnt8 - v0);
        end
        checks++;
        if (vdata8 !== 8'h3C || p_data8 !== 8'h3C) begin
            failures++;
            $display("FAIL w8_data: got %h/%h required 3c", vdata8, p_data8);
        end
        checks++;
        if (sclk_rises8 - s0 != 8 || pl_low8 - l0 != 4) begin
            failures++;
            $display("FAIL w8_pulses: rises=%0d pl_low=%0d required 8/4", sclk_rises8 - s0, pl_low8 - l0);
        end
        checks++;
        if (valid_cyc8 - pl_fall_cyc8 != 36) begin
            failures++;
            $display("FAIL w8_latency: got %0d required 36", valid_cyc8 - pl_fall_cyc8);
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_busy_guard();
        test_back_to_back();
        test_width8();
        test_reset_mid_shift();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
